prio_code_decoder: RTL and testbench

PRIO_CODE_DECODER -- requirements
Module: prio_code_decoder

---
 rtl/prio_code_decoder.sv | 140 ++++++++++++++
 tb/tb_prio_code_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_code_decoder.sv
// Priority-code to active-low one-hot line decoder with hold/gap pacing.
// Optional invalid-code counter port err_cnt under PRIO_CODE_DEC_ERR_CNT_EN.
module prio_code_decoder #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_n,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       err_sticky
`ifdef PRIO_CODE_DEC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [7:0] HOLD_L =
    (HOLD_CYC == 0) ? 8'd1 : 8'(HOLD_CYC);
  localparam logic [7:0] GAP_L = 8'(GAP_CYC);

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_out_n;
  logic       r_live;
  logic       r_done;
  logic       r_err;
  logic       r_sticky;

  logic [7:0] w_dec;
  logic       w_vld;
  logic       w_xfer;

  assign in_ready   = r_live & (r_state == S_IDLE);
  assign w_xfer     = in_valid & in_ready;
  assign busy       = (r_state != S_IDLE);
  assign out_n      = r_out_n;
  assign done       = r_done;
  assign err        = r_err;
  assign err_sticky = r_sticky;

  always_comb begin
    w_dec = 8'hFF;
    w_vld = 1'b1;
    case (code)
      4'b1000: w_dec = 8'h7F;
      4'b1001: w_dec = 8'hBF;
      4'b1010: w_dec = 8'hDF;
      4'b1011: w_dec = 8'hEF;
      4'b1100: w_dec = 8'hF7;
      4'b1110: w_dec = 8'hFB;
      4'b1111: w_dec = 8'hFD;
      4'b0001: w_dec = 8'hFE;
      4'b0000: w_dec = 8'hFF;
      default: w_vld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_out_n  <= 8'hFF;
      r_live   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && w_vld) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_L;
            r_out_n <= w_dec;
          end else if (w_xfer) begin
            r_err    <= 1'b1;
            r_sticky <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt <= 8'd1) begin
            r_out_n <= 8'hFF;
            if (GAP_L == 8'd0) begin
              r_state <= S_IDLE;
              r_cnt   <= 8'd0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= GAP_L;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (r_cnt <= 8'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
          r_out_n <= 8'hFF;
        end
      endcase
    end
  end

`ifdef PRIO_CODE_DEC_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  assign err_cnt = r_err_cnt;

  // saturating count of accepted invalid codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_xfer && !w_vld && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prio_code_decoder.sv
// Directed testbench for prio_code_decoder (default and zero hold/gap).
// Honours PRIO_CODE_DEC_ERR_CNT_EN when defined.
module tb_prio_code_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_n;
  logic       busy;
  logic       done;
  logic       err;
  logic       err_sticky;

  logic [3:0] z_code;
  logic       z_valid;
  logic       z_ready;
  logic [7:0] z_out_n;
  logic       z_busy;
  logic       z_done;
  logic       z_err;
  logic       z_sticky;

`ifdef PRIO_CODE_DEC_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic [7:0] z_err_cnt;
`endif

  int checks;
  int failures;

  prio_code_decoder #(.HOLD_CYC(4), .GAP_CYC(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_n      (out_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_sticky (err_sticky)
`ifdef PRIO_CODE_DEC_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  prio_code_decoder #(.HOLD_CYC(0), .GAP_CYC(0)) u_dut_z (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (z_code),
    .in_valid   (z_valid),
    .in_ready   (z_ready),
    .out_n      (z_out_n),
    .busy       (z_busy),
    .done       (z_done),
    .err        (z_err),
    .err_sticky (z_sticky)
`ifdef PRIO_CODE_DEC_ERR_CNT_EN
    ,
    .err_cnt    (z_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c);
    code     = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  logic [3:0] codes [8];
  logic [7:0] decs  [8];

  initial begin
    checks   = 0;
    failures = 0;
    codes = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF, 4'h1};
    decs  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF,
              8'hF7, 8'hFB, 8'hFD, 8'hFE};
    rst_n    = 1'b0;
    code     = 4'h0;
    in_valid = 1'b0;
    z_code   = 4'h0;
    z_valid  = 1'b0;

    step();
    chk("rst_out_n", 32'(out_n), 32'hFF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(in_ready), 1);

    // code 1000: hold 4, gap 1, done in cycle 6
    send(4'b1000);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("hold_c%0d", i), 32'(out_n), 32'h7F);
      chk($sformatf("hold_busy%0d", i), 32'(busy), 1);
      chk($sformatf("hold_rdy%0d", i), 32'(in_ready), 0);
      step();
    end
    chk("gap_out_n", 32'(out_n), 32'hFF);
    chk("gap_done", 32'(done), 0);
    chk("gap_busy", 32'(busy), 1);
    step();
    chk("c6_done", 32'(done), 1);
    chk("c6_ready", 32'(in_ready), 1);
    chk("c6_busy", 32'(busy), 0);
    step();
    chk("done_pulse_end", 32'(done), 0);

    for (int k = 0; k < 8; k++) begin
      send(codes[k]);
      chk($sformatf("sweep_%0h", codes[k]), 32'(out_n), 32'(decs[k]));
      repeat (5) step();
      chk($sformatf("sweep_rdy_%0h", codes[k]), 32'(in_ready), 1);
    end

    send(4'b0000);
    chk("zero_out_n", 32'(out_n), 32'hFF);
    chk("zero_busy", 32'(busy), 1);
    repeat (5) step();
    chk("zero_done", 32'(done), 1);

    send(4'b1101);
    chk("inv1_err", 32'(err), 1);
    chk("inv1_busy", 32'(busy), 0);
    chk("inv1_out_n", 32'(out_n), 32'hFF);
    chk("inv1_sticky", 32'(err_sticky), 1);
    chk("inv1_done", 32'(done), 0);
    chk("inv1_ready", 32'(in_ready), 1);
    send(4'b0101);
    chk("inv2_err", 32'(err), 1);
    chk("inv2_busy", 32'(busy), 0);
    chk("inv2_out_n", 32'(out_n), 32'hFF);
    step();
    chk("inv_err_end", 32'(err), 0);
    chk("inv_sticky_hold", 32'(err_sticky), 1);
`ifdef PRIO_CODE_DEC_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 2);
`endif

    // continuous valid, code changes every cycle
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      code = codes[c % 8];
      step();
      if (c % 6 < 4)
        chk($sformatf("stream_%0d", c), 32'(out_n),
            32'(decs[(c - c % 6) % 8]));
      else
        chk($sformatf("stream_%0d", c), 32'(out_n), 32'hFF);
    end
    in_valid = 1'b0;
    step();

    // reset in 2nd hold cycle of 1100
    send(4'b1100);
    chk("pre_rst_out", 32'(out_n), 32'hF7);
    step();
    chk("pre_rst_sticky", 32'(err_sticky), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_n", 32'(out_n), 32'hFF);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_sticky", 32'(err_sticky), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_ready", 32'(in_ready), 1);

    // zero hold/gap: one cycle hold, accept again next cycle
    z_code  = 4'b1000;
    z_valid = 1'b1;
    step();
    chk("z_hold_out", 32'(z_out_n), 32'h7F);
    chk("z_hold_rdy", 32'(z_ready), 0);
    z_code = 4'b0001;
    step();
    chk("z_idle_out", 32'(z_out_n), 32'hFF);
    chk("z_idle_done", 32'(z_done), 1);
    chk("z_idle_rdy", 32'(z_ready), 1);
    step();
    chk("z_next_out", 32'(z_out_n), 32'hFE);
    z_valid = 1'b0;
    step();
    chk("z_next_done", 32'(z_done), 1);
    chk("z_sticky", 32'(z_sticky), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
